uart_rx: RTL and testbench

//  Oversampling UART receiver: the downstream partner of the UART transmitter on the same link.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rx_bit_sampler.sv | 42 ++++
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity convention, default frame width.
package uart_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Frame format captured when a start edge is accepted
    typedef struct packed {
        logic par_en;
        logic par_typ;
    } rx_cfg_t;

endpackage

// File: rtl/rx_bit_sampler.sv
// Bit-period tick counter and 3-sample majority vote around the middle of each bit.
module rx_bit_sampler #(
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic rx_s,
    output logic bit_done_c,
    output logic bit_val_c
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);

    logic [TW-1:0] tick_cnt;
    logic          s0;
    logic          s1;

    // Tick counter runs only while a frame is in progress; first two votes are stored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else if (!run) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : TW'(tick_cnt + 1'b1);
            if (tick_cnt == TICK_S0) s0 <= rx_s;
            if (tick_cnt == TICK_S1) s1 <= rx_s;
        end
    end

    // Third vote is the live sample, so the decision lands on the next edge
    assign bit_done_c = run && (tick_cnt == TICK_S2);
    assign bit_val_c  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB-first, optional parity, one stop bit.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    import uart_pkg::*;

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t             state, state_d;
    rx_cfg_t               cfg, cfg_d;
    logic                  rx_meta, rx_s;
    logic                  armed, armed_d;
    logic [BW-1:0]         bit_cnt, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic                  rx_par, rx_par_d;
    logic [DATA_WIDTH-1:0] p_data_d;
    logic                  data_valid_d, par_err_d, stp_err_d, busy_d;
    logic                  par_bad;
    logic                  bit_done_c, bit_val_c;

    // Two-flop synchronizer, preset to the idle level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .run        (state != IDLE),
        .rx_s       (rx_s),
        .bit_done_c (bit_done_c),
        .bit_val_c  (bit_val_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cfg        <= '0;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_par     <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cfg        <= cfg_d;
            armed      <= armed_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            rx_par     <= rx_par_d;
            p_data     <= p_data_d;
            data_valid <= data_valid_d;
            par_err    <= par_err_d;
            stp_err    <= stp_err_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-output logic; strobes default low so they last one cycle
    always_comb begin
        state_d      = state;
        cfg_d        = cfg;
        armed_d      = armed;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        rx_par_d     = rx_par;
        p_data_d     = p_data;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        busy_d       = busy;
        par_bad      = cfg.par_en && (rx_par != ((^shreg) ^ (cfg.par_typ == PAR_ODD)));

        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_d = START;
                    busy_d  = 1'b1;
                    cfg_d   = '{par_en: par_en, par_typ: par_typ};
                end else if (rx_s) begin
                    armed_d = 1'b1;
                end
            end
            START: begin
                if (bit_done_c) begin
                    if (bit_val_c) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    shreg_d = {bit_val_c, shreg[DATA_WIDTH-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        state_d = cfg.par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = BW'(bit_cnt + 1'b1);
                    end
                end
            end
            PARITY: begin
                if (bit_done_c) begin
                    rx_par_d = bit_val_c;
                    state_d  = STOP;
                end
            end
            STOP: begin
                // Decided mid-stop so a following start edge is not missed
                if (bit_done_c) begin
                    if (bit_val_c && !par_bad) begin
                        p_data_d     = shreg;
                        data_valid_d = 1'b1;
                    end
                    stp_err_d = !bit_val_c;
                    par_err_d = par_bad;
                    busy_d    = 1'b0;
                    armed_d   = rx_s;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx;

    localparam int unsigned OS = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          par_en;
    logic          par_typ;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    typedef struct {
        int       cyc;
        bit       dv;
        bit       pe;
        bit       se;
        bit [7:0] data;
    } ev_t;

    int            cyc = 0;
    ev_t           evq[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            busy_cnt = 0;
    int            pdata_bad = 0;
    logic [DW-1:0] prev_pdata = '0;
    logic [DW-1:0] last_good = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: record every strobe, count busy cycles, catch p_data moving without data_valid
    always @(negedge clk) begin
        if (data_valid || par_err || stp_err) begin
            ev_t e;
            e.cyc  = cyc;
            e.dv   = data_valid;
            e.pe   = par_err;
            e.se   = stp_err;
            e.data = p_data;
            evq.push_back(e);
        end
        if (busy) busy_cnt++;
        if (rst && (p_data !== prev_pdata) && !data_valid) pdata_bad++;
        prev_pdata = p_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; bit period given in hundredths of a clock cycle. Leaves rx_in at the stop level.
    task automatic send_frame(input logic [7:0] d, input bit with_par, input bit pbit, input bit stop,
                              input int per100, input bit scramble, output int start_cyc);
        bit bits[11];
        int nb;
        int total;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        nb = 9;
        if (with_par) begin
            bits[9] = pbit;
            nb = 10;
        end
        bits[nb] = stop;
        nb++;
        total = (nb * per100) / 100;
        start_cyc = cyc;
        for (int c = 0; c < total; c++) begin
            rx_in = bits[(c * 100) / per100];
            if (scramble && c == 40) begin
                par_en  = ~par_en;
                par_typ = ~par_typ;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Full frame at nominal rate, checked against the frame-level model
    task automatic run_frame(input string tag, input logic [7:0] d, input bit pen, input bit ptyp,
                             input bit corrupt, input bit stop, input bit scramble);
        int  start_cyc;
        bit  pbit;
        bit  par_ok;
        bit  exp_dv;
        int  exp_cyc;
        ev_t e;
        pbit = 1'(($countones(d) % 2)) ^ ptyp ^ corrupt;
        par_en  = pen;
        par_typ = ptyp;
        send_frame(d, pen, pbit, stop, OS * 100, scramble, start_cyc);
        rx_in = 1'b1;
        idle(14);
        // Total ones over data+parity must be odd for odd parity, even for even parity
        par_ok  = !pen || ((($countones(d) + int'(pbit)) % 2) == int'(ptyp));
        exp_dv  = stop && par_ok;
        // 2 sync flops + 1 detect edge, then the stop-bit decision latency
        exp_cyc = start_cyc + 3 + (pen ? 10 : 9) * OS + OS / 2 + 2;
        check({tag, "_nstrobe"}, 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check({tag, "_dv"}, 32'(e.dv), 32'(exp_dv));
            check({tag, "_par_err"}, 32'(e.pe), 32'(!par_ok));
            check({tag, "_stp_err"}, 32'(e.se), 32'(!stop));
            check({tag, "_cycle"}, 32'(e.cyc), 32'(exp_cyc));
        end
        evq.delete();
        if (exp_dv) last_good = d;
        check({tag, "_p_data"}, 32'(p_data), 32'(last_good));
    endtask

    initial begin
        int  sc;
        ev_t e;
        rst     = 1'b0;
        rx_in   = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outputs", 32'({p_data, data_valid, par_err, stp_err}), 32'd0);
        rst = 1'b1;
        idle(4);

        run_frame("t1_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("t2_3c_even", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("t2_3c_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame("t3_01_odd", 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Stop bit low, then a long break: exactly one stp_err and no new frame
        par_en = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, OS * 100, 1'b0, sc);
        rx_in = 1'b0;
        idle(4);
        busy_cnt = 0;
        idle(40 * OS);
        check("t4_break_busy", 32'(busy_cnt), 32'd0);
        check("t4_nstrobe", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check("t4_flags", 32'({e.dv, e.pe, e.se}), 32'b001);
            check("t4_cycle", 32'(e.cyc), 32'(sc + 3 + 9 * OS + OS / 2 + 2));
        end
        evq.delete();
        rx_in = 1'b1;
        idle(10);

        // Two-cycle low glitch: busy for the start-bit vote only, nothing delivered
        busy_cnt = 0;
        rx_in = 1'b0;
        idle(2);
        rx_in = 1'b1;
        idle(20);
        check("t5_glitch_busy", 32'(busy_cnt), 32'(OS / 2 + 2));
        check("t5_glitch_nstrobe", 32'(evq.size()), 32'd0);
        evq.delete();
        run_frame("t5_5a", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back frames at a 2% slow bit period
        par_en = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, OS * 102, 1'b0, sc);
        send_frame(8'hEE, 1'b0, 1'b0, 1'b1, OS * 102, 1'b0, sc);
        rx_in = 1'b1;
        idle(14);
        check("t6_nstrobe", 32'(evq.size()), 32'd2);
        if (evq.size() >= 2) begin
            e = evq.pop_front();
            check("t6_first", 32'({e.dv, e.pe, e.se, e.data}), 32'({3'b100, 8'h11}));
            e = evq.pop_front();
            check("t6_second", 32'({e.dv, e.pe, e.se, e.data}), 32'({3'b100, 8'hEE}));
        end
        evq.delete();
        last_good = 8'hEE;
        check("t6_p_data", 32'(p_data), 32'(last_good));

        for (int n = 0; n < 20; n++) begin
            run_frame($sformatf("rnd%0d", n), 8'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 7) != 0), 1'b1);
        end

        // Reset in the middle of a frame, held until the line is idle again
        par_en = 1'b0;
        fork
            send_frame(8'hC3, 1'b0, 1'b0, 1'b1, OS * 100, 1'b0, sc);
            begin
                idle(30);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("t6_rst_busy", 32'(busy), 32'd0);
                check("t6_rst_outputs", 32'({p_data, data_valid, par_err, stp_err}), 32'd0);
            end
        join
        rx_in = 1'b1;
        idle(10);
        check("t6_rst_nstrobe", 32'(evq.size()), 32'd0);
        rst = 1'b1;
        idle(10);
        check("t6_rst_idle", 32'({busy, p_data}), 32'd0);
        check("p_data_stable", 32'(pdata_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
